// File: rtl/fm_pkg.sv
// fm_pkg: types and helpers shared by the FM frame mixer and its sample FIFO.
package fm_pkg;

  // Sequencer states: wait for the sample tick, walk every slot, finish the frame.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_PROCESS,
    ST_NEXT
  } fm_state_e;

  // Default audio sample width and the stereo word layout carried by the FIFO.
  localparam int FM_SAMPLE_W = 16;

  typedef struct packed {
    logic signed [FM_SAMPLE_W-1:0] l;
    logic signed [FM_SAMPLE_W-1:0] r;
  } fm_stereo_t;

  // Largest value representable in a w-bit two's complement sample.
  function automatic longint fm_sat_max(input int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a w-bit two's complement sample.
  function automatic longint fm_sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/fm_sample_fifo.sv
// fm_sample_fifo: small synchronous FIFO with full/empty flags. A pop and a
// push in the same cycle are both accepted when full; a pop when empty is ignored.
module fm_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: the storage array has no reset; the read port is forced to zero while
  // empty, so nothing stale is ever visible and the array stays plain storage.
  // Write the incoming word at the write pointer.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  // Advance pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fm_frame_mixer.sv
// fm_frame_mixer: walks all operator slots once per sample tick, pans and
// accumulates each slot result, saturates the frame and queues it for output.
// Optional peak meters are built when FM_FRAME_MIXER_PEAK_EN is defined.
module fm_frame_mixer
  import fm_pkg::*;
#(
  parameter int NUM_OPS    = 64,
  parameter int SAMPLE_DIV = 506,
  parameter int RES_W      = 13,
  parameter int ACC_W      = 19,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [$clog2(NUM_OPS)-1:0] op_sel,
  output logic                       op_next,
  output logic                       op_reset,
  input  logic                       op_valid,
  input  logic signed [RES_W-1:0]    op_result,
  input  logic                       do_sum,
  input  logic [7:0]                 pan_l,
  input  logic [7:0]                 pan_r,
  input  logic                       cfg_wren,
  output logic                       cfg_wait,
  output logic signed [OUT_W-1:0]    sample_l,
  output logic signed [OUT_W-1:0]    sample_r,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       overrun,
  output logic [7:0]                 drop_cnt,
  input  logic                       stat_clr,
  output logic [OUT_W-2:0]           peak_l,
  output logic [OUT_W-2:0]           peak_r,
  input  logic                       peak_clr
);

  localparam int SEL_W  = $clog2(NUM_OPS);
  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int PROD_W = RES_W + 9;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(fm_sat_max(OUT_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(fm_sat_min(OUT_W));

  // Same {l, r} layout as fm_stereo_t, sized by OUT_W.
  typedef struct packed {
    logic signed [OUT_W-1:0] l;
    logic signed [OUT_W-1:0] r;
  } frame_t;

  fm_state_e               state;
  logic [DIV_W-1:0]        div_cnt;
  logic                    tick;
  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic signed [PROD_W-1:0] prod_l, prod_r;
  logic signed [ACC_W-1:0] panned_l, panned_r;
  logic                    last_slot;
  logic                    frame_push;
  frame_t                  push_word, head_word;
  logic                    fifo_full, fifo_empty;
  logic                    drop;

  // Pan gain is unsigned 0..255; the floor shift keeps negative results rounding down.
  assign prod_l   = PROD_W'(op_result) * PROD_W'($signed({1'b0, pan_l}));
  assign prod_r   = PROD_W'(op_result) * PROD_W'($signed({1'b0, pan_r}));
  assign panned_l = ACC_W'(prod_l >>> 8);
  assign panned_r = ACC_W'(prod_r >>> 8);

  assign last_slot  = (op_sel == SEL_W'(NUM_OPS - 1));
  assign frame_push = (state == ST_NEXT) && last_slot;
  assign cfg_wait   = cfg_wren && (state != ST_IDLE);

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned and a latch cannot be inferred.
  // Clamp each frame sum into the output sample range.
  always_comb begin
    push_word.l = OUT_W'(acc_l);
    push_word.r = OUT_W'(acc_r);
    if (acc_l > ACC_MAX) push_word.l = OUT_W'(ACC_MAX);
    else if (acc_l < ACC_MIN) push_word.l = OUT_W'(ACC_MIN);
    if (acc_r > ACC_MAX) push_word.r = OUT_W'(ACC_MAX);
    else if (acc_r < ACC_MIN) push_word.r = OUT_W'(ACC_MIN);
  end

  // Free-running sample divider; the tick lands one cycle after the wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == DIV_W'(SAMPLE_DIV - 1));
      div_cnt <= (div_cnt == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // Slot sequencer with the frame accumulators.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_sel   <= '0;
      op_next  <= 1'b0;
      op_reset <= 1'b1;
      acc_l    <= '0;
      acc_r    <= '0;
    end else begin
      op_next <= 1'b0;
      case (state)
        ST_IDLE: if (tick) state <= ST_START;
        ST_START: begin
          op_sel <= '0;
          state  <= ST_PROCESS;
        end
        ST_PROCESS: if (op_valid) begin
          if (!op_reset && do_sum) begin
            acc_l <= acc_l + panned_l;
            acc_r <= acc_r + panned_r;
          end
          op_next <= 1'b1;
          state   <= ST_NEXT;
        end
        ST_NEXT: begin
          if (last_slot) begin
            acc_l    <= '0;
            acc_r    <= '0;
            op_reset <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            op_sel <= op_sel + SEL_W'(1);
            state  <= ST_PROCESS;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fm_sample_fifo #(
    .WIDTH (2 * OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (frame_push),
    .pop     (sample_ready),
    .wr_data (push_word),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign sample_valid = !fifo_empty;
  assign sample_l     = head_word.l;
  assign sample_r     = head_word.r;
  assign drop         = frame_push && fifo_full && !(sample_valid && sample_ready);

  // Sticky status; a clear beats a set landing in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else if (stat_clr) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (tick && state != ST_IDLE) overrun <= 1'b1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef FM_FRAME_MIXER_PEAK_EN
  logic [OUT_W-1:0] abs_l, abs_r;
  logic [OUT_W-2:0] mag_l, mag_r;

  // Only the most negative sample has a magnitude past the top bit; clamp it.
  assign abs_l = push_word.l[OUT_W-1] ? $unsigned(-push_word.l) : $unsigned(push_word.l);
  assign abs_r = push_word.r[OUT_W-1] ? $unsigned(-push_word.r) : $unsigned(push_word.r);
  assign mag_l = abs_l[OUT_W-1] ? '1 : abs_l[OUT_W-2:0];
  assign mag_r = abs_r[OUT_W-1] ? '1 : abs_r[OUT_W-2:0];

  // Track the largest magnitude; a clear alongside a push restarts from that push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_l <= '0;
      peak_r <= '0;
    end else if (frame_push) begin
      if (peak_clr || mag_l > peak_l) peak_l <= mag_l;
      if (peak_clr || mag_r > peak_r) peak_r <= mag_r;
    end else if (peak_clr) begin
      peak_l <= '0;
      peak_r <= '0;
    end
  end
`else
  logic unused_peak_clr;

  assign unused_peak_clr = peak_clr;
  assign peak_l          = '0;
  assign peak_r          = '0;
`endif

endmodule
